// File: rtl/cond_unit.sv
// Condition-check and flag stage: holds NZCV, evaluates the IR condition once per
// instruction, gates decoder write strobes and counts executed/annulled instructions.
module cond_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IRWrite,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             RegWHi,
    input  logic             MemW,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             RegWriteHi,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    typedef enum logic {
        S_HOLD = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               cond_ex_q, cond_ex_d;
    logic [3:0]         flags_q, flags_d;
    logic [CNT_W-1:0]   exec_q, exec_d;
    logic [CNT_W-1:0]   skip_q, skip_d;
    logic               cond_pass_c;
    logic               gate_c;

    // ARM condition table over {N,Z,C,V}; 1111 is treated as always.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic r;
        {n, z, c, v} = f;
        unique case (cond)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = c;
            4'b0011: r = !c;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = c & !z;
            4'b1001: r = !c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z & (n == v);
            4'b1101: r = z | (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    assign cond_pass_c = cond_eval(Cond, flags_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_HOLD;
            cond_ex_q <= 1'b0;
            flags_q   <= 4'b0000;
            exec_q    <= '0;
            skip_q    <= '0;
        end else begin
            state_q   <= state_d;
            cond_ex_q <= cond_ex_d;
            flags_q   <= flags_d;
            exec_q    <= exec_d;
            skip_q    <= skip_d;
        end
    end

    // Evaluation happens only in PEND; flags move only while an executed instruction holds.
    always_comb begin
        state_d   = IRWrite ? S_PEND : S_HOLD;
        cond_ex_d = cond_ex_q;
        flags_d   = flags_q;
        exec_d    = exec_q;
        skip_d    = skip_q;
        if (state_q == S_PEND) begin
            cond_ex_d = cond_pass_c;
            if (cond_pass_c) begin
                if (exec_q != '1) exec_d = exec_q + CNT_W'(1);
            end else begin
                if (skip_q != '1) skip_d = skip_q + CNT_W'(1);
            end
        end else if (cond_ex_q && !IRWrite) begin
            if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    assign gate_c     = reset & cond_ex_q;
    assign PCWrite    = reset & (NextPC | (PCS & cond_ex_q));
    assign RegWrite   = RegW & gate_c;
    assign RegWriteHi = RegWHi & gate_c;
    assign MemWrite   = MemW & gate_c;
    assign CondEx     = cond_ex_q;
    assign Flags      = flags_q;
    assign ExecCount  = exec_q;
    assign SkipCount  = skip_q;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: stimulus queues per-cycle expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_cond_unit;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned EXP_W = 9 + 2 * CNT_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             IRWrite;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS, NextPC, RegW, RegWHi, MemW;
    logic             PCWrite, RegWrite, RegWriteHi, MemWrite, CondEx;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] ExecCount, SkipCount;

    always #5 clk = ~clk;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .IRWrite(IRWrite), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .RegWHi(RegWHi),
        .MemW(MemW), .PCWrite(PCWrite), .RegWrite(RegWrite), .RegWriteHi(RegWriteHi),
        .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags), .ExecCount(ExecCount),
        .SkipCount(SkipCount)
    );

    typedef struct {
        int               due;
        logic [EXP_W-1:0] exp;
        logic [63:0]      tag;
    } sb_t;

    sb_t              sb_q[$];
    int               cyc = 0;
    int               n_vec = 0;
    int               n_bad = 0;
    logic             done = 1'b0;
    logic             e_condex;
    logic [3:0]       e_flags;
    logic [CNT_W-1:0] e_exec, e_skip;
    logic [63:0]      tag;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected layout: {CondEx, Flags, ExecCount, SkipCount, PCWrite, RegWrite, RegWriteHi, MemWrite}
    always @(negedge clk) begin : monitor
        sb_t              s;
        logic [EXP_W-1:0] obs;
        obs = {CondEx, Flags, ExecCount, SkipCount, PCWrite, RegWrite, RegWriteHi, MemWrite};
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            s = sb_q.pop_front();
            n_vec++;
            if (s.due != cyc || obs !== s.exp) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got %b required %b", s.tag, cyc, obs, s.exp);
            end
        end
        if (done && sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: %0d unchecked entries, required 0", sb_q.size());
            sb_q.delete();
        end
    end

    // Reference condition table grouped by condition pair; odd codes invert (except 111x).
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic r;
        case (c[3:1])
            3'd0: r = f[2];
            3'd1: r = f[1];
            3'd2: r = f[3];
            3'd3: r = f[0];
            3'd4: r = f[1] & ~f[2];
            3'd5: r = ~(f[3] ^ f[0]);
            3'd6: r = ~f[2] & ~(f[3] ^ f[0]);
            default: r = 1'b1;
        endcase
        if (c[0] && c[3:1] != 3'd7) r = ~r;
        return r;
    endfunction

    task automatic drive(input logic rst, input logic irw, input logic [3:0] cond,
                         input logic [1:0] fw, input logic [3:0] alu, input logic pcs,
                         input logic npc, input logic rw, input logic rwh, input logic mw);
        sb_t  s;
        logic g;
        @(posedge clk);
        #1;
        reset = rst; IRWrite = irw; Cond = cond; FlagW = fw; ALUFlags = alu;
        PCS = pcs; NextPC = npc; RegW = rw; RegWHi = rwh; MemW = mw;
        g = rst & e_condex;
        s.due = cyc;
        s.tag = tag;
        s.exp = {e_condex, e_flags, e_exec, e_skip, rst & (npc | (pcs & e_condex)),
                 rw & g, rwh & g, mw & g};
        sb_q.push_back(s);
    endtask

    task automatic eval(input logic pass);
        e_condex = pass;
        if (pass) begin
            if (e_exec != '1) e_exec = e_exec + CNT_W'(1);
        end else begin
            if (e_skip != '1) e_skip = e_skip + CNT_W'(1);
        end
    endtask

    task automatic instr(input logic [3:0] cond, input logic pass);
        drive(1'b1, 1'b1, cond, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, cond, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        eval(pass);
    endtask

    task automatic exec(input logic [1:0] fw, input logic [3:0] alu, input logic pcs,
                        input logic npc, input logic rw, input logic rwh, input logic mw,
                        input logic [3:0] new_flags);
        drive(1'b1, 1'b0, Cond, fw, alu, pcs, npc, rw, rwh, mw);
        e_flags = new_flags;
    endtask

    initial begin
        reset = 1'b0; IRWrite = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; RegWHi = 1'b0; MemW = 1'b0;
        e_condex = 1'b0; e_flags = 4'h0; e_exec = '0; e_skip = '0;

        tag = "reset";
        repeat (2) drive(1'b0, 1'b0, 4'h0, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        tag = "setz";
        instr(4'hE, 1'b1);
        exec(2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);

        tag = "eq_pass";
        instr(4'h0, 1'b1);
        exec(2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100);

        tag = "ne_fail";
        instr(4'h1, 1'b0);
        exec(2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0100);

        tag = "flagw";
        instr(4'hE, 1'b1);
        exec(2'b10, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100);
        exec(2'b01, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
        exec(2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
        instr(4'h1, 1'b0);
        exec(2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
        exec(2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);

        tag = "suppress";
        instr(4'hE, 1'b1);
        drive(1'b1, 1'b1, 4'hE, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 4'hE, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        eval(1'b1);
        exec(2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);

        // Fetch overlapping PEND: NE (fails on Z=1) then EQ (passes).
        tag = "irw_pend";
        drive(1'b1, 1'b1, 4'h1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'h1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        eval(1'b0);
        drive(1'b1, 1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        eval(1'b1);
        exec(2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111);

        for (int f = 0; f < 16; f++) begin
            tag = "setflag";
            instr(4'hE, 1'b1);
            exec(2'b11, 4'(f), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(f));
            for (int c = 0; c < 16; c++) begin
                tag = "sweep";
                instr(4'(c), ref_cond(4'(c), 4'(f)));
                exec(2'b00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, e_flags);
            end
        end

        tag = "sat";
        for (int i = 0; i < 16; i++) begin
            instr(4'hE, 1'b1);
            exec(2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_flags);
        end

        tag = "branch";
        instr(4'h1, 1'b0);
        exec(2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_flags);
        exec(2'b00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e_flags);
        instr(4'hE, 1'b1);
        exec(2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_flags);

        tag = "midrst";
        drive(1'b1, 1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'hE, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        e_condex = 1'b0; e_flags = 4'h0; e_exec = '0; e_skip = '0;
        exec(2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
        exec(2'b00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
        instr(4'hE, 1'b1);
        exec(2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);

        @(posedge clk);
        done = 1'b1;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
